// File: rtl/keyed_secded_pkg.sv
// Shared types and helpers for the keyed SECDED pipeline.
// Holds the codeword position map, check-width derivation and result class.
package keyed_secded_pkg;

    typedef enum logic [1:0] {
        CLEAN,
        SEC,
        DED
    } cls_e;

    // Total check bits: Hamming bits plus one overall parity bit.
    function automatic int chk_w(input int hchk_w);
        return hchk_w + 1;
    endfunction

    // Codeword position of data bit i: the i-th position (from 1 upward)
    // that is not a power of two. Position 3 is the first such slot.
    function automatic int data_pos(input int i);
        int n;
        int r;
        n = 0;
        r = 0;
        for (int p = 3; p < 256; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == i) r = p;
                n++;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/keyed_secded_pipe_if.sv
// Handshake bundle between a word source/sink and the SECDED pipeline.
// master: drives in_* and out_ready; slave: the pipeline side.
interface keyed_secded_pipe_if #(
    parameter int DATA_W = 32,
    parameter int HCHK_W = 6
);
    localparam int CHK_W = HCHK_W + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CHK_W-1:0]  in_chk;
    logic              chk_en;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [HCHK_W-1:0] out_syn;
    logic              out_sec;
    logic              out_ded;

    modport master (
        output in_valid, in_data, in_chk, chk_en, out_ready,
        input  in_ready, out_valid, out_data, out_syn, out_sec, out_ded
    );

    modport slave (
        input  in_valid, in_data, in_chk, chk_en, out_ready,
        output in_ready, out_valid, out_data, out_syn, out_sec, out_ded
    );

endinterface

// File: rtl/secded_syndrome.sv
// Combinational Hamming syndrome and overall parity of one codeword.
// Ports: data, chk (overall parity in the MSB) -> syn, par.
module secded_syndrome
    import keyed_secded_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int HCHK_W = 6
) (
    input  logic [DATA_W-1:0] data,
    input  logic [HCHK_W:0]   chk,
    output logic [HCHK_W-1:0] syn,
    output logic              par
);

    // Check bit j sits at position 2^j, so it contributes exactly bit j.
    always_comb begin
        syn = chk[HCHK_W-1:0];
        for (int i = 0; i < DATA_W; i++) begin
            if (data[i]) syn = syn ^ HCHK_W'(data_pos(i));
        end
        par = ^{data, chk};
    end

endmodule

// File: rtl/keyed_secded_pipe.sv
// Two-stage SECDED corrector with a locking key and event counters.
// Ports: clk, rst_n, key_in/key_load, bus (slave), corr_cnt, ded_cnt, key_ok.
module keyed_secded_pipe
    import keyed_secded_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                HCHK_W     = 6,
    parameter int                KEY_W      = 2,
    parameter logic [KEY_W-1:0]  KEY_VAL    = 2'b11,
    parameter logic [HCHK_W-1:0] DECOY_MASK = 6'd22
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_W-1:0]   key_in,
    input  logic               key_load,
    keyed_secded_pipe_if.slave bus,
    output logic [15:0]        corr_cnt,
    output logic [15:0]        ded_cnt,
    output logic               key_ok
);

    localparam int CHK_W = chk_w(HCHK_W);
    localparam int N_POS = DATA_W + HCHK_W;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [CHK_W-1:0]  s1_chk;

    logic [HCHK_W-1:0] syn;
    logic              par;
    logic [HCHK_W-1:0] eff;
    logic [DATA_W-1:0] fix;
    cls_e              cls;

    logic [KEY_W-1:0]  key_q;
    logic [KEY_W-1:0]  key_nxt;
    logic              s2_ready;
    logic              out_hs;

    secded_syndrome #(
        .DATA_W (DATA_W),
        .HCHK_W (HCHK_W)
    ) u_syn (
        .data (s1_data),
        .chk  (s1_chk),
        .syn  (syn),
        .par  (par)
    );

    assign s2_ready     = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_ready;
    assign out_hs       = bus.out_valid && bus.out_ready;
    assign key_nxt      = key_load ? key_in : key_q;

    // A wrong key silently scrambles the syndrome so the corrector
    // misbehaves instead of refusing to run.
    always_comb begin
        eff = key_ok ? syn : (syn ^ DECOY_MASK);
        cls = CLEAN;
        fix = '0;
        unique case (1'b1)
            !par && (eff == '0): cls = CLEAN;
            !par && (eff != '0): cls = DED;
            par && (int'(eff) > N_POS): cls = DED;
            par && (int'(eff) <= N_POS): cls = SEC;
        endcase
        // Syndrome 0 or a check position leaves fix all-zero.
        if (cls == SEC) begin
            for (int i = 0; i < DATA_W; i++) begin
                if (int'(eff) == data_pos(i)) fix[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1_data       <= '0;
            s1_chk        <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_syn   <= '0;
            bus.out_sec   <= 1'b0;
            bus.out_ded   <= 1'b0;
            corr_cnt      <= '0;
            ded_cnt       <= '0;
            key_q         <= '0;
            key_ok        <= 1'b0;
        end else begin
            if (bus.in_ready) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_data <= bus.in_data;
                    s1_chk  <= bus.chk_en ? bus.in_chk : '0;
                end
            end
            if (s2_ready) begin
                bus.out_valid <= s1_valid;
                if (s1_valid) begin
                    bus.out_data <= s1_data ^ fix;
                    bus.out_syn  <= eff;
                    bus.out_sec  <= (cls == SEC);
                    bus.out_ded  <= (cls == DED);
                end
            end
            if (out_hs && bus.out_sec && (corr_cnt != 16'hFFFF))
                corr_cnt <= corr_cnt + 16'd1;
            if (out_hs && bus.out_ded && (ded_cnt != 16'hFFFF))
                ded_cnt <= ded_cnt + 16'd1;
            key_q  <= key_nxt;
            key_ok <= (key_nxt == KEY_VAL);
        end
    end

endmodule
